// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - shared state encodings, gear codes and gear cap helper for drive_ctrl
package drive_pkg;

    typedef enum logic [1:0] {
        DRIVE     = 2'd0,
        BRAKE     = 2'd1,
        RAMP_DOWN = 2'd2,
        DEADTIME  = 2'd3
    } drive_state_e;

    localparam logic [2:0] GEAR_NEUTRAL = 3'd0;
    localparam logic [2:0] GEAR_REVERSE = 3'd7;

    // Highest speed level allowed in a gear; unused codes behave as neutral.
    function automatic int gear_cap(input logic [2:0] gear, input int levels, input int num_gears);
        int g;
        g = int'({29'd0, gear});
        if (gear == GEAR_REVERSE)
            return (levels - 1) / num_gears;
        else if (g != 0 && g <= num_gears)
            return (g * (levels - 1)) / num_gears;
        else
            return 0;
    endfunction

endpackage

// File: rtl/drive_pwm_core.sv
// rtl/drive_pwm_core.sv - free-running PWM counter with end-of-period duty latch and registered compare
module drive_pwm_core #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                kill,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty_q;
    logic                pwm_q;

    // duty_q only changes at the period boundary so no period is ever cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            cnt   <= cnt + PWM_BITS'(1);
            pwm_q <= (cnt < duty_q);
            if (cnt == '1)
                duty_q <= duty;
        end
    end

    assign pwm_out = pwm_q & ~kill;

endmodule

// File: rtl/drive_ctrl.sv
// rtl/drive_ctrl.sv - speed/gear/ramp/brake/direction controller with PWM; DRIVE_ODOMETER_EN adds odometer output
module drive_ctrl
    import drive_pkg::*;
#(
    parameter int LEVELS      = 16,
    parameter int NUM_GEARS   = 5,
    parameter int PWM_BITS    = 8,
    parameter int RAMP_DIV    = 1000,
    parameter int RAMP_STEP   = 1,
    parameter int BRAKE_STEP  = 8,
    parameter int DEAD_CYCLES = 100,
    localparam int LEVEL_W    = $clog2(LEVELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                accel_pulse,
    input  logic                decel_pulse,
    input  logic                brake,
    input  logic [2:0]          gear,
    output logic [LEVEL_W-1:0]  speed_level,
    output logic [PWM_BITS-1:0] duty,
    output logic                pwm_out,
    output logic                dir,
    output logic [1:0]          state
`ifdef DRIVE_ODOMETER_EN
    ,
    output logic [23:0]         odometer
`endif
);

    localparam int DUTY_MAX     = (1 << PWM_BITS) - 1;
    localparam int DUTY_PER_LVL = DUTY_MAX / (LEVELS - 1);
    localparam int DIV_W        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W       = $clog2(DEAD_CYCLES + 1);

    drive_state_e        st;
    logic [DIV_W-1:0]    div_cnt;
    logic [DEAD_W-1:0]   dead_cnt;
    logic                ramp_tick;
    logic                rev_req;
    logic                pwm_kill;
    logic [LEVEL_W-1:0]  cap;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] step;

    assign cap       = LEVEL_W'(gear_cap(gear, LEVELS, NUM_GEARS));
    assign rev_req   = (gear == GEAR_REVERSE);
    assign ramp_tick = (div_cnt == DIV_W'(RAMP_DIV - 1));
    assign target    = (st == DRIVE) ? PWM_BITS'(32'(speed_level) * DUTY_PER_LVL) : '0;
    assign step      = (st == BRAKE) ? PWM_BITS'(BRAKE_STEP) : PWM_BITS'(RAMP_STEP);
    assign state     = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else
            div_cnt <= ramp_tick ? '0 : div_cnt + DIV_W'(1);
    end

    // Step toward target, landing exactly on it when closer than one step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= '0;
        end else if (ramp_tick) begin
            if (duty < target)
                duty <= (target - duty > step) ? duty + step : target;
            else if (duty > target)
                duty <= (duty - target > step) ? duty - step : target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= DRIVE;
            speed_level <= '0;
            dir         <= 1'b0;
            dead_cnt    <= '0;
            pwm_kill    <= 1'b0;
        end else begin
            case (st)
                DRIVE: begin
                    if (brake) begin
                        st          <= BRAKE;
                        speed_level <= '0;
                    end else if (rev_req != dir) begin
                        if (duty == '0) begin
                            st       <= DEADTIME;
                            pwm_kill <= 1'b1;
                        end else begin
                            st <= RAMP_DOWN;
                        end
                    end else if (speed_level > cap) begin
                        speed_level <= cap;
                    end else if (accel_pulse && !decel_pulse && speed_level < cap) begin
                        speed_level <= speed_level + LEVEL_W'(1);
                    end else if (decel_pulse && !accel_pulse && speed_level != '0) begin
                        speed_level <= speed_level - LEVEL_W'(1);
                    end
                end
                BRAKE: begin
                    if (!brake)
                        st <= DRIVE;
                end
                RAMP_DOWN: begin
                    if (brake) begin
                        st          <= BRAKE;
                        speed_level <= '0;
                    end else if (rev_req == dir) begin
                        st <= DRIVE;
                    end else if (duty == '0) begin
                        st       <= DEADTIME;
                        pwm_kill <= 1'b1;
                    end
                end
                DEADTIME: begin
                    // Brake is deliberately not sampled here; DRIVE picks it up after the flip.
                    if (dead_cnt == DEAD_W'(DEAD_CYCLES - 1)) begin
                        dead_cnt    <= '0;
                        dir         <= ~dir;
                        speed_level <= '0;
                        pwm_kill    <= 1'b0;
                        st          <= DRIVE;
                    end else begin
                        dead_cnt <= dead_cnt + DEAD_W'(1);
                    end
                end
            endcase
        end
    end

    drive_pwm_core #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty    (duty),
        .kill    (pwm_kill),
        .pwm_out (pwm_out)
    );

`ifdef DRIVE_ODOMETER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            odometer <= '0;
        else if (ramp_tick)
            odometer <= (odometer > 24'hFFFFFF - 24'(speed_level)) ? 24'hFFFFFF
                                                                   : odometer + 24'(speed_level);
    end
`endif

endmodule
